gmii_tx_sched: RTL and testbench
================================

GMII_TX_SCHED -- requirements
Module: gmii_tx_sched

Interface
REQ-001 The module SHALL have one parameter: IPG_CYCLES, default 12, minimum Tx_en_o-low cycles between frames (range 4..15).
REQ-002 The module SHALL use one clock and one reset; reset_i is asynchronous and active-high.
REQ-003 Port list (name, direction, width, meaning):
- clk125_i  in  1  125 MHz GMII transmit clock
- reset_i  in  1  async active-high reset
- en_i  in  1  enable; 0 = no new grants
- s0_data_i  in  8  requester 0 frame byte (DA..FCS, no preamble)
- s0_valid_i  in  1  requester 0 byte valid / frame request
- s0_last_i  in  1  requester 0 last byte of frame
- s0_ready_o  out  1  requester 0 byte accepted
- s1_data_i, s1_valid_i, s1_last_i, s1_ready_o  as requester 0, for requester 1
- Txd_o  out  8  GMII transmit data, to the RGMII bridge
- Tx_en_o  out  1  GMII transmit enable
- Tx_er_o  out  1  GMII transmit error
- busy_o  out  1  state != IDLE
- frame_cnt0_o  out  16  frames completed by requester 0, wraps
- frame_cnt1_o  out  16  frames completed by requester 1, wraps
- abort_cnt_o  out  8  underrun aborts, saturates at 255

Function
REQ-004 States SHALL be IDLE, PRE, SFD, DATA, IPG.
REQ-005 In IDLE with en_i=1 and any sX_valid_i=1, the module SHALL grant one requester and move to PRE. Grant is round-robin: if both are valid, grant the one not granted last. After reset, requester 0 has priority.
REQ-006 Grant SHALL be held until the frame ends (last byte or abort). It SHALL NOT change mid-frame.
REQ-007 Outputs Txd_o, Tx_en_o and Tx_er_o SHALL be registered. If the grant decision is made in cycle T:
- T+1..T+7: Txd_o = 0x55, Tx_en_o = 1
- T+8: Txd_o = 0xD5 (SFD)
- T+9 onward: first frame byte
REQ-008 sX_ready_o SHALL be asserted only for the granted requester, in cycles T+8 onward while in SFD/DATA and until its last byte is accepted. It SHALL be combinational from state and grant only, never from valid.
REQ-009 A byte SHALL be accepted when ready and valid are both 1. An accepted byte SHALL appear on Txd_o, with Tx_en_o=1 and Tx_er_o=0, exactly one cycle later.
REQ-010 After the last byte is accepted in cycle L, the module SHALL:
- drive Tx_en_o=0 from L+2;
- increment the granted requester's frame counter;
- hold Tx_en_o low for exactly IPG_CYCLES cycles before the next preamble when a request is already pending.
REQ-011 Underrun: if the granted requester has valid=0 while ready=1 in DATA, the next cycle SHALL output Tx_en_o=1, Tx_er_o=1, Txd_o=0x00. The FSM SHALL then go to IPG, and abort_cnt_o SHALL increment (saturating). No frame count is recorded.
- Because of the 1-cycle latency, there is no Tx_en gap between bytes of a frame.
REQ-012 When IPG completes, the FSM SHALL go to IDLE. Arbitration is re-evaluated there, so back-to-back traffic alternates requesters.
REQ-013 en_i SHALL be sampled only in IDLE. Deasserting it mid-frame SHALL let the current frame and its IPG complete.
REQ-014 Txd_o SHALL be 0x00 whenever Tx_en_o=0.
REQ-015 If s0_last_i and an underrun would apply in the same cycle, valid=0 means underrun. last is qualified by valid.

Reset
REQ-016 Reset SHALL set:
- state = IDLE, grant pointer = requester 0;
- Txd_o = 0x00; Tx_en_o, Tx_er_o, busy_o and both sX_ready_o = 0;
- all counters = 0.
REQ-017 Reset asserted mid-frame SHALL force Tx_en_o=0 immediately (asynchronously), with no Tx_er_o pulse.

Structure
REQ-018 Package gmii_tx_pkg SHALL hold:
- the state enum typedef;
- PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5, PREAMBLE_LEN = 7.
REQ-019 The two-way round-robin grant SHALL be one sub-module, rr_arb2 (inputs: req[1:0], advance; output: one-hot grant).
REQ-020 Preamble and IPG counters SHALL be 4 bits wide.

Verification
REQ-021 Single frame: s0 sends a 64-byte frame 0x01..0x40 with no bubbles. Expected:
- Tx_en_o high for 72 cycles (7×0x55, 0xD5, 0x01..0x40);
- frame_cnt0_o = 1.
REQ-022 Contention: s0 and s1 both valid from reset, each with two 60-byte frames. Expected:
- grant order s0, s1, s0, s1;
- exactly 12 Tx_en_o-low cycles between frames.
REQ-023 Underrun: s1 drops valid after byte 10. Expected:
- one cycle with Tx_en_o=1, Tx_er_o=1, Txd_o=0x00, then Tx_en_o=0;
- abort_cnt_o = 1, frame_cnt1_o unchanged.
REQ-024 Enable: en_i=0 with s0 valid → Tx_en_o stays 0. Raise en_i → preamble starts 1 cycle after grant. Clear en_i mid-frame → frame completes.
REQ-025 Reset mid-DATA (byte 20) → Tx_en_o=0 immediately. After release with s0 valid → a fresh preamble is output and the counters read 0.
REQ-026 Saturation: force 256 underruns → abort_cnt_o = 255.

Source files
------------

// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_IPG
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [3:0] PREAMBLE_LEN  = 4'd7;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins;
// requester 0 wins ties after reset.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic pri_q;
  logic pri_d;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || !pri_q)) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  always_comb begin
    pri_d = pri_q;
    if (advance_i && gnt_o[0]) begin
      pri_d = 1'b1;
    end else if (advance_i && gnt_o[1]) begin
      pri_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII transmit scheduler: arbitrates two byte-stream requesters, prepends
// preamble/SFD, enforces the inter-packet gap and flags source underruns.
module gmii_tx_sched
  import gmii_tx_pkg::*;
#(
  parameter int unsigned IPG_CYCLES = 12
) (
  input  logic        clk125_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [7:0]  s0_data_i,
  input  logic        s0_valid_i,
  input  logic        s0_last_i,
  output logic        s0_ready_o,
  input  logic [7:0]  s1_data_i,
  input  logic        s1_valid_i,
  input  logic        s1_last_i,
  output logic        s1_ready_o,
  output logic [7:0]  Txd_o,
  output logic        Tx_en_o,
  output logic        Tx_er_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt0_o,
  output logic [15:0] frame_cnt1_o,
  output logic [7:0]  abort_cnt_o
);

  localparam logic [3:0] PRE_LAST = PREAMBLE_LEN - 4'd1;
  localparam logic [3:0] IPG_LAST = 4'(IPG_CYCLES - 1);

  state_e      state_q, state_d;
  logic        gsel_q, gsel_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  ipg_cnt_q, ipg_cnt_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic [15:0] fcnt0_q, fcnt0_d;
  logic [15:0] fcnt1_q, fcnt1_d;
  logic [7:0]  abort_q, abort_d;

  logic [1:0]  gnt;
  logic        advance;
  logic        xfer_st;
  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign advance = (state_q == ST_IDLE) && en_i && (s0_valid_i || s1_valid_i);

  rr_arb2 u_arb (
    .clk_i     (clk125_i),
    .rst_i     (reset_i),
    .req_i     ({s1_valid_i, s0_valid_i}),
    .advance_i (advance),
    .gnt_o     (gnt)
  );

  // Ready depends only on state and the held grant, never on valid.
  assign xfer_st    = (state_q == ST_SFD) || (state_q == ST_DATA);
  assign s0_ready_o = xfer_st && !gsel_q;
  assign s1_ready_o = xfer_st && gsel_q;
  assign busy_o     = (state_q != ST_IDLE);

  assign sel_valid = gsel_q ? s1_valid_i : s0_valid_i;
  assign sel_last  = gsel_q ? s1_last_i  : s0_last_i;
  assign sel_data  = gsel_q ? s1_data_i  : s0_data_i;

  always_comb begin
    state_d   = state_q;
    gsel_d    = gsel_q;
    pre_cnt_d = pre_cnt_q;
    ipg_cnt_d = ipg_cnt_q;
    txd_d     = 8'h00;
    tx_en_d   = 1'b0;
    tx_er_d   = 1'b0;
    fcnt0_d   = fcnt0_q;
    fcnt1_d   = fcnt1_q;
    abort_d   = abort_q;
    unique case (state_q)
      ST_IDLE: begin
        if (advance) begin
          gsel_d    = gnt[1] & ~gnt[0];
          pre_cnt_d = 4'd0;
          txd_d     = PREAMBLE_BYTE;
          tx_en_d   = 1'b1;
          state_d   = ST_PRE;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        if (pre_cnt_q == PRE_LAST) begin
          txd_d   = SFD_BYTE;
          state_d = ST_SFD;
        end else begin
          txd_d     = PREAMBLE_BYTE;
          pre_cnt_d = pre_cnt_q + 4'd1;
        end
      end
      ST_SFD, ST_DATA: begin
        // Next-cycle output mirrors the accepted byte; a missing byte aborts.
        tx_en_d   = 1'b1;
        ipg_cnt_d = 4'd0;
        if (sel_valid) begin
          txd_d   = sel_data;
          state_d = ST_DATA;
          if (sel_last) begin
            state_d = ST_IPG;
            if (gsel_q) fcnt1_d = fcnt1_q + 16'd1;
            else        fcnt0_d = fcnt0_q + 16'd1;
          end
        end else begin
          tx_er_d = 1'b1;
          state_d = ST_IPG;
          abort_d = sat_inc8(abort_q);
        end
      end
      ST_IPG: begin
        if (ipg_cnt_q == IPG_LAST) begin
          state_d = ST_IDLE;
        end else begin
          ipg_cnt_d = ipg_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk125_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      gsel_q    <= 1'b0;
      pre_cnt_q <= 4'd0;
      ipg_cnt_q <= 4'd0;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      fcnt0_q   <= 16'd0;
      fcnt1_q   <= 16'd0;
      abort_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      gsel_q    <= gsel_d;
      pre_cnt_q <= pre_cnt_d;
      ipg_cnt_q <= ipg_cnt_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      tx_er_q   <= tx_er_d;
      fcnt0_q   <= fcnt0_d;
      fcnt1_q   <= fcnt1_d;
      abort_q   <= abort_d;
    end
  end

  assign Txd_o        = txd_q;
  assign Tx_en_o      = tx_en_q;
  assign Tx_er_o      = tx_er_q;
  assign frame_cnt0_o = fcnt0_q;
  assign frame_cnt1_o = fcnt1_q;
  assign abort_cnt_o  = abort_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Bench for gmii_tx_sched: frame-level reference model (round-robin order,
// expected on-wire burst per frame, gap length, counters) over random frames.
`timescale 1ns/1ps
module tb_gmii_tx_sched;

  localparam int IPG = 12;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        en_i = 1'b0;
  logic [7:0]  s0_data_i = 8'h00, s1_data_i = 8'h00;
  logic        s0_valid_i = 1'b0, s0_last_i = 1'b0;
  logic        s1_valid_i = 1'b0, s1_last_i = 1'b0;
  logic        s0_ready_o, s1_ready_o;
  logic [7:0]  Txd_o;
  logic        Tx_en_o, Tx_er_o, busy_o;
  logic [15:0] fc0, fc1;
  logic [7:0]  ab;

  always #4 clk = ~clk;

  gmii_tx_sched #(.IPG_CYCLES(IPG)) dut (
    .clk125_i     (clk),
    .reset_i      (reset_i),
    .en_i         (en_i),
    .s0_data_i    (s0_data_i),
    .s0_valid_i   (s0_valid_i),
    .s0_last_i    (s0_last_i),
    .s0_ready_o   (s0_ready_o),
    .s1_data_i    (s1_data_i),
    .s1_valid_i   (s1_valid_i),
    .s1_last_i    (s1_last_i),
    .s1_ready_o   (s1_ready_o),
    .Txd_o        (Txd_o),
    .Tx_en_o      (Tx_en_o),
    .Tx_er_o      (Tx_er_o),
    .busy_o       (busy_o),
    .frame_cnt0_o (fc0),
    .frame_cnt1_o (fc1),
    .abort_cnt_o  (ab)
  );

  typedef struct {
    int src;
    int start;
    int len;
    int und_k;   // bytes delivered before the source stalls; -1 = complete frame
  } frame_t;

  frame_t     frames[$];
  logic [7:0] pool[$];
  int         list [2][0:511];
  int         tail[2], dhead[2], mhead[2], bidx[2];
  bit         dropped[2];
  logic [8:0] cur[$];
  bit         in_burst, gap_valid, mdl_last;
  int         gap, burst_gap;
  int         exp_fc[2];
  int         exp_ab;
  int         vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int s, input int len, input int und_k, input bit ramp);
    frame_t f;
    f.src = s; f.start = pool.size(); f.len = len; f.und_k = und_k;
    for (int i = 0; i < len; i++) pool.push_back(ramp ? 8'(i + 1) : 8'($urandom));
    list[s][tail[s]] = frames.size();
    tail[s]++;
    frames.push_back(f);
  endtask

  task automatic clear_test();
    for (int s = 0; s < 2; s++) begin
      tail[s] = 0; dhead[s] = 0; mhead[s] = 0; bidx[s] = 0; dropped[s] = 1'b0;
    end
    gap_valid = 1'b0;
  endtask

  task automatic drive_src();
    frame_t     f;
    logic       v, l;
    logic [7:0] d;
    for (int s = 0; s < 2; s++) begin
      v = 1'b0; l = 1'($urandom_range(0, 1)); d = 8'($urandom);
      if (dhead[s] < tail[s] && !dropped[s]) begin
        f = frames[list[s][dhead[s]]];
        v = 1'b1; d = pool[f.start + bidx[s]]; l = (bidx[s] == f.len - 1);
      end
      if (s == 0) begin s0_valid_i = v; s0_data_i = d; s0_last_i = l; end
      else        begin s1_valid_i = v; s1_data_i = d; s1_last_i = l; end
    end
  endtask

  // Frame-level model: pick the expected frame by round-robin over pending
  // frames and build the expected burst: 7x55, D5, payload, [error cycle].
  task automatic check_burst();
    int s, nexp, nbad;
    frame_t f;
    logic [8:0] e;
    if (mhead[0] < tail[0] && (mhead[1] >= tail[1] || mdl_last)) s = 0;
    else if (mhead[1] < tail[1]) s = 1;
    else begin
      chk("spurious_burst_len", 32'(cur.size()), 32'd0);
      return;
    end
    f = frames[list[s][mhead[s]]];
    mhead[s]++;
    mdl_last = s[0];
    nexp = 8 + ((f.und_k < 0) ? f.len : f.und_k + 1);
    chk($sformatf("s%0d_burst_len", s), 32'(cur.size()), 32'(nexp));
    nbad = 0;
    for (int i = 0; i < nexp && i < cur.size(); i++) begin
      if (i < 7)                               e = {1'b0, 8'h55};
      else if (i == 7)                         e = {1'b0, 8'hD5};
      else if (f.und_k >= 0 && i == nexp - 1)  e = {1'b1, 8'h00};
      else                                     e = {1'b0, pool[f.start + i - 8]};
      if (cur[i] !== e) nbad++;
    end
    chk($sformatf("s%0d_burst_bytes_bad", s), 32'(nbad), 32'd0);
    if (gap_valid) chk("ipg_gap", 32'(burst_gap), 32'(IPG));
    gap_valid = 1'b1;
    if (f.und_k < 0) exp_fc[s]++;
    else if (exp_ab < 255) exp_ab++;
  endtask

  task automatic monitor();
    if (!Tx_en_o) chk("txd_when_idle", {23'd0, Tx_er_o, Txd_o}, 32'd0);
    if (Tx_en_o) begin
      if (!in_burst) begin
        in_burst = 1'b1; burst_gap = gap; cur.delete();
      end
      cur.push_back({Tx_er_o, Txd_o});
    end else begin
      if (in_burst) begin
        in_burst = 1'b0; check_burst(); gap = 0;
      end
      gap++;
    end
  endtask

  task automatic step();
    bit acc[2], und[2];
    frame_t f;
    @(negedge clk);
    acc[0] = s0_ready_o && s0_valid_i;  acc[1] = s1_ready_o && s1_valid_i;
    und[0] = s0_ready_o && !s0_valid_i; und[1] = s1_ready_o && !s1_valid_i;
    chk("ready_exclusive", 32'(s0_ready_o & s1_ready_o), 32'd0);
    @(posedge clk);
    #1;
    monitor();
    for (int s = 0; s < 2; s++) begin
      if (dhead[s] < tail[s]) begin
        f = frames[list[s][dhead[s]]];
        if (acc[s]) begin
          bidx[s]++;
          if (bidx[s] == f.und_k) dropped[s] = 1'b1;
          else if (bidx[s] == f.len) begin dhead[s]++; bidx[s] = 0; end
        end else if (und[s] && dropped[s]) begin
          dhead[s]++; bidx[s] = 0; dropped[s] = 1'b0;
        end
      end
    end
    drive_src();
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    while ((dhead[0] < tail[0] || dhead[1] < tail[1] || busy_o || in_burst) && n < maxc) begin
      step();
      n++;
    end
    chk("run_within_budget", 32'(n < maxc), 32'd1);
    chk("frames_not_seen", 32'((tail[0] - mhead[0]) + (tail[1] - mhead[1])), 32'd0);
    chk("frame_cnt0", 32'(fc0), 32'(exp_fc[0]));
    chk("frame_cnt1", 32'(fc1), 32'(exp_fc[1]));
    chk("abort_cnt", 32'(ab), 32'(exp_ab));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    clear_test();
    mdl_last = 1'b1;
    exp_fc = '{0, 0};
    exp_ab = 0;
    in_burst = 1'b0;
    gap = 0;
    cur.delete();
    drive_src();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog sim_time=%0t limit=1ms", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int len, und;
    do_reset();
    chk("rst_txd", 32'(Txd_o), 32'd0);
    chk("rst_tx_en", 32'(Tx_en_o), 32'd0);
    chk("rst_tx_er", 32'(Tx_er_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'({s1_ready_o, s0_ready_o}), 32'd0);
    chk("rst_counters", 32'(fc0 | fc1 | 16'(ab)), 32'd0);
    en_i = 1'b1;

    // single 64-byte ramp frame from s0
    clear_test();
    load(0, 64, -1, 1'b1);
    run_idle(500);

    // contention from reset: two 60-byte frames per requester
    do_reset();
    for (int i = 0; i < 2; i++) begin
      load(0, 60, -1, 1'b0);
      load(1, 60, -1, 1'b0);
    end
    run_idle(1500);

    // s1 underrun after byte 10
    clear_test();
    load(1, 20, 10, 1'b0);
    run_idle(500);

    // enable gating
    clear_test();
    load(0, 30, -1, 1'b0);
    en_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("en_low_tx_en", 32'(Tx_en_o), 32'd0);
      chk("en_low_busy", 32'(busy_o), 32'd0);
    end
    en_i = 1'b1;
    step();
    chk("en_rise_tx_en", 32'(Tx_en_o), 32'd1);
    chk("en_rise_txd", 32'(Txd_o), 32'h55);
    repeat (20) step();
    en_i = 1'b0;
    run_idle(500);
    en_i = 1'b1;

    // random mixed traffic with occasional underruns
    clear_test();
    for (int i = 0; i < 10; i++) begin
      for (int s = 0; s < 2; s++) begin
        len = int'($urandom_range(1, 40));
        und = (len >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
        load(s, len, und, 1'b0);
      end
    end
    run_idle(6000);

    // reset mid-frame at byte 20
    clear_test();
    load(0, 40, -1, 1'b0);
    n = 0;
    while (bidx[0] < 20 && n < 200) begin step(); n++; end
    chk("reached_byte20", 32'(bidx[0]), 32'd20);
    chk("pre_reset_tx_en", 32'(Tx_en_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_rst_tx_en", 32'(Tx_en_o), 32'd0);
    chk("async_rst_tx_er", 32'(Tx_er_o), 32'd0);
    chk("async_rst_txd", 32'(Txd_o), 32'd0);
    do_reset();
    chk("post_rst_counters", 32'(fc0 | fc1 | 16'(ab)), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    load(0, 16, -1, 1'b0);
    run_idle(300);

    // 256 underruns saturate the abort counter
    clear_test();
    for (int i = 0; i < 128; i++) begin
      load(0, 2, 1, 1'b0);
      load(1, 2, 1, 1'b0);
    end
    run_idle(20000);
    chk("abort_saturated", 32'(ab), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
